// File: rtl/mod_exp_param_if.sv
// Bus bundle for mod_exp_param: operand load, start/status, Montgomery product
// port and result readback.
interface mod_exp_param_if #(
  parameter int WORD_W = 128,
  parameter int NWORDS = 32
);
  localparam int AW = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  logic              ld_valid;
  logic [1:0]        ld_sel;
  logic [AW-1:0]     ld_addr;
  logic [WORD_W-1:0] ld_word;
  logic              start;
  logic              busy;
  logic              done;
  logic              err;
  logic [15:0]       op_count;
  logic              mp_start;
  logic              mp_in_valid;
  logic [WORD_W-1:0] mp_opa;
  logic [WORD_W-1:0] mp_opb;
  logic              mp_res_valid;
  logic [WORD_W-1:0] mp_res;
  logic [AW-1:0]     rd_addr;
  logic [WORD_W-1:0] rd_data;

  modport slave (
    input  ld_valid, ld_sel, ld_addr, ld_word, start, mp_res_valid, mp_res, rd_addr,
    output busy, done, err, op_count, mp_start, mp_in_valid, mp_opa, mp_opb, rd_data
  );

  modport master (
    output ld_valid, ld_sel, ld_addr, ld_word, start, mp_res_valid, mp_res, rd_addr,
    input  busy, done, err, op_count, mp_start, mp_in_valid, mp_opa, mp_opb, rd_data
  );
endinterface

// File: rtl/mod_exp_param.sv
// Left-to-right Montgomery exponentiation m = c^d mod n driving an external MonPro unit.
// MOD_EXP_CONST_TIME_EN: skip the leading-zero scan and multiply on every exponent bit.
module mod_exp_param #(
  parameter int WORD_W = 128,
  parameter int NWORDS = 32
) (
  input logic            clk,
  input logic            reset,
  mod_exp_param_if.slave bus
);
  localparam int AW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int NB = WORD_W * NWORDS;
  localparam int KW = $clog2(NB);
  localparam int IW = $clog2(NWORDS + 1);
  localparam logic [KW-1:0] K_TOP     = KW'(NB - 1);
  localparam logic [IW-1:0] FEED_LAST = IW'(NWORDS);
  localparam logic [IW-1:0] RES_LAST  = IW'(NWORDS - 1);
`ifdef MOD_EXP_CONST_TIME_EN
  localparam bit CONST_TIME = 1'b1;
`else
  localparam bit CONST_TIME = 1'b0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_SCAN, S_SQR, S_MUL, S_POST, S_FIN} state_t;
  // WAIT is folded into COLLECT: the phase simply idles until the next result word.
  typedef enum logic {PH_FEED, PH_COLLECT} phase_t;

  state_t            state_q, state_d;
  phase_t            ph_q, ph_d;
  logic [IW-1:0]     cnt_q, cnt_d;
  logic [KW-1:0]     k_q, k_d;
  logic              err_q, err_d;
  logic [15:0]       op_count_q, op_count_d;
  logic [WORD_W-1:0] rd_data_q;

  logic [WORD_W-1:0] c_q [NWORDS];
  logic [WORD_W-1:0] t_q [NWORDS];
  logic [WORD_W-1:0] r_q [NWORDS];
  logic [WORD_W-1:0] m_q [NWORDS];
  logic [WORD_W-1:0] cbar_q [NWORDS];
  logic [NB-1:0]     d_q;

  logic              is_prod, busy, accept, feed_start, feed_valid;
  logic              res_take, call_end, d_bit, last_bit, wr_m, wr_cbar;
  logic [AW-1:0]     widx, cidx;
  logic [WORD_W-1:0] opa, opb;

  assign is_prod    = state_q inside {S_PRE, S_SQR, S_MUL, S_POST};
  assign busy       = !(state_q inside {S_IDLE, S_FIN});
  assign accept     = bus.start && !busy;
  assign feed_start = is_prod && (ph_q == PH_FEED) && (cnt_q == '0);
  assign feed_valid = is_prod && (ph_q == PH_FEED) && (cnt_q != '0);
  assign res_take   = is_prod && (ph_q == PH_COLLECT) && bus.mp_res_valid;
  assign call_end   = res_take && (cnt_q == RES_LAST);
  assign widx       = AW'(cnt_q - IW'(1));
  assign cidx       = AW'(cnt_q);
  assign d_bit      = d_q[k_q];
  assign last_bit   = (k_q == '0);
  // A const-time MUL on a zero exponent bit still runs but its result is dropped.
  assign wr_m       = res_take && (state_q != S_PRE) && !((state_q == S_MUL) && !d_bit);
  assign wr_cbar    = res_take && (state_q == S_PRE);

  always_comb begin
    opa = '0;
    opb = '0;
    if (feed_valid) begin
      case (state_q)
        S_PRE:   begin opa = c_q[widx]; opb = t_q[widx];    end
        S_SQR:   begin opa = m_q[widx]; opb = m_q[widx];    end
        S_MUL:   begin opa = m_q[widx]; opb = cbar_q[widx]; end
        S_POST:  begin opa = m_q[widx]; opb = (widx == '0) ? WORD_W'(1) : '0; end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    ph_d       = ph_q;
    cnt_d      = cnt_q;
    k_d        = k_q;
    err_d      = err_q;
    op_count_d = op_count_q;
    if (accept) begin
      err_d      = 1'b0;
      op_count_d = '0;
    end else if (busy && (bus.ld_valid || bus.start)) begin
      err_d = 1'b1;
    end
    if (feed_start) op_count_d = op_count_q + 16'd1;

    if (is_prod) begin
      if (ph_q == PH_FEED) begin
        if (cnt_q == FEED_LAST) begin
          ph_d  = PH_COLLECT;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + IW'(1);
        end
      end else if (res_take) begin
        cnt_d = cnt_q + IW'(1);
        if (call_end) begin
          ph_d  = PH_FEED;
          cnt_d = '0;
        end
      end
    end

    case (state_q)
      S_IDLE, S_FIN: begin
        if (state_q == S_FIN) state_d = S_IDLE;
        if (accept) begin
          state_d = S_PRE;
          k_d     = K_TOP;
        end
      end
      S_PRE:  if (call_end) state_d = CONST_TIME ? S_SQR : S_SCAN;
      S_SCAN: begin
        if (d_bit)         state_d = S_SQR;
        else if (last_bit) state_d = S_POST;
        else               k_d     = k_q - KW'(1);
      end
      S_SQR, S_MUL: begin
        if (call_end) begin
          if ((state_q == S_SQR) && (d_bit || CONST_TIME)) begin
            state_d = S_MUL;
          end else begin
            state_d = last_bit ? S_POST : S_SQR;
            if (!last_bit) k_d = k_q - KW'(1);
          end
        end
      end
      S_POST:  if (call_end) state_d = S_FIN;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ph_q       <= PH_FEED;
      cnt_q      <= '0;
      k_q        <= '0;
      err_q      <= 1'b0;
      op_count_q <= '0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      ph_q       <= ph_d;
      cnt_q      <= cnt_d;
      k_q        <= k_d;
      err_q      <= err_d;
      op_count_q <= op_count_d;
      rd_data_q  <= m_q[bus.rd_addr];
    end
  end

  // Operand and result storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (bus.ld_valid && !busy) begin
      case (bus.ld_sel)
        2'd0: c_q[bus.ld_addr] <= bus.ld_word;
        2'd1: t_q[bus.ld_addr] <= bus.ld_word;
        2'd2: r_q[bus.ld_addr] <= bus.ld_word;
        default: d_q[int'(bus.ld_addr) * WORD_W +: WORD_W] <= bus.ld_word;
      endcase
    end
    if (feed_start && (state_q == S_PRE)) m_q <= r_q;
    if (wr_m)    m_q[cidx]    <= bus.mp_res;
    if (wr_cbar) cbar_q[cidx] <= bus.mp_res;
  end

  assign bus.busy        = busy;
  assign bus.done        = (state_q == S_FIN);
  assign bus.err         = err_q;
  assign bus.op_count    = op_count_q;
  assign bus.mp_start    = feed_start;
  assign bus.mp_in_valid = feed_valid;
  assign bus.mp_opa      = opa;
  assign bus.mp_opb      = opb;
  assign bus.rd_data     = rd_data_q;
endmodule
